// File: rtl/hazard_stall_unit_if.sv
// Pipeline-side signal bundle for the hazard/stall controller.
// The hazard unit uses the slave view; the pipeline (or a bench) uses the master view.
interface hazard_stall_unit_if #(
  parameter int STALL_CNT_W = 16,
  parameter int FLUSH_CNT_W = 8
);
  // ID-stage operands and control
  logic [4:0]             IfId_Rs;
  logic [4:0]             IfId_Rt;
  logic                   Ctrl_UsesRt;
  logic                   Ctrl_Branch;
  logic                   Branch_Taken;
  // EX-stage producer
  logic                   IdEx_MemRead;
  logic                   IdEx_Reg_Wr_Control;
  logic [4:0]             IdEx_Rd;
  // MEM-stage producer
  logic                   ExMem_MemRead;
  logic [4:0]             ExMem_Rd;
  // Pipeline control back to the datapath
  logic                   PcWrite;
  logic                   IfIdWrite;
  logic                   IdExBubble;
  logic                   IfIdFlush;
  // Status and statistics
  logic                   Hazard_Busy;
  logic [STALL_CNT_W-1:0] Stall_Cycles;
  logic [FLUSH_CNT_W-1:0] Flush_Count;

  modport master (
    output IfId_Rs, IfId_Rt, Ctrl_UsesRt, Ctrl_Branch, Branch_Taken,
    output IdEx_MemRead, IdEx_Reg_Wr_Control, IdEx_Rd, ExMem_MemRead, ExMem_Rd,
    input  PcWrite, IfIdWrite, IdExBubble, IfIdFlush,
    input  Hazard_Busy, Stall_Cycles, Flush_Count
  );

  modport slave (
    input  IfId_Rs, IfId_Rt, Ctrl_UsesRt, Ctrl_Branch, Branch_Taken,
    input  IdEx_MemRead, IdEx_Reg_Wr_Control, IdEx_Rd, ExMem_MemRead, ExMem_Rd,
    output PcWrite, IfIdWrite, IdExBubble, IfIdFlush,
    output Hazard_Busy, Stall_Cycles, Flush_Count
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for the 5-stage pipeline. Detects load-use,
// branch-after-ALU and branch-after-load hazards, freezes PC and IF/ID,
// injects ID/EX bubbles, flushes IF/ID on taken branches, and keeps
// saturating stall/flush statistics.
module hazard_stall_unit #(
  parameter int STALL_CNT_W = 16,
  parameter int FLUSH_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hazard_stall_unit_if.slave   hz
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STALL1 = 2'd1,
    S_STALL2 = 2'd2   // reserved entry point, never entered
  } state_t;

  state_t                 state_q;
  logic                   busy_q;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic m_ex, m_mem;
  logic hz_lu, hz_ba, hz_bl2, hz_bl1, hz_len1;
  logic stall, flush;

  // Register-match terms and hazard classification; register 0 never matches
  always_comb begin
    m_ex    = (hz.IdEx_Rd != 5'd0) &&
              ((hz.IdEx_Rd == hz.IfId_Rs) || (hz.Ctrl_UsesRt && (hz.IdEx_Rd == hz.IfId_Rt)));
    m_mem   = (hz.ExMem_Rd != 5'd0) &&
              ((hz.ExMem_Rd == hz.IfId_Rs) || (hz.Ctrl_UsesRt && (hz.ExMem_Rd == hz.IfId_Rt)));
    hz_lu   = hz.IdEx_MemRead && m_ex && !hz.Ctrl_Branch;
    hz_ba   = hz.Ctrl_Branch && hz.IdEx_Reg_Wr_Control && !hz.IdEx_MemRead && m_ex;
    hz_bl2  = hz.Ctrl_Branch && hz.IdEx_MemRead && m_ex;
    hz_bl1  = hz.Ctrl_Branch && hz.ExMem_MemRead && m_mem;
    hz_len1 = hz_bl1 || hz_ba || hz_lu;
  end

  // Mealy pipeline control: stall in STALL1 or on any IDLE hazard; flush only when
  // nothing stalls; everything forced to the idle default while in reset
  always_comb begin
    stall = 1'b0;
    flush = 1'b0;
    if (rst_n) begin
      if (state_q == S_STALL1) begin
        stall = 1'b1;
      end else if (state_q == S_IDLE) begin
        stall = hz_bl2 || hz_len1;
        flush = !stall && hz.Ctrl_Branch && hz.Branch_Taken;
      end
    end
    hz.PcWrite    = !stall;
    hz.IfIdWrite  = !stall;
    hz.IdExBubble = stall;
    hz.IfIdFlush  = flush;
  end

  // Stall FSM: BL2 needs one extra held cycle, everything else resolves in IDLE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (hz_bl2) begin
            state_q <= S_STALL1;
            busy_q  <= 1'b1;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Saturating next-count for the statistics counters
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (flush && (flush_cnt_q != {FLUSH_CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  // Statistics registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.Hazard_Busy  = busy_q;
  assign hz.Stall_Cycles = stall_cnt_q;
  assign hz.Flush_Count  = flush_cnt_q;

endmodule
